// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared types, mode constants and checksum helper for the DHT reader
package dht_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_START_REL,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK
  } dht_state_e;

  localparam int MODE_DHT11 = 0;
  localparam int MODE_DHT22 = 1;

  localparam int FRAME_BITS = 40;

  typedef logic [FRAME_BITS-1:0] dht_frame_t;

  function automatic logic checksum_ok(input dht_frame_t f);
    logic [7:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return sum == f[7:0];
  endfunction

endpackage

// File: rtl/dht_line_sync.sv
// rtl/dht_line_sync.sv - multi-stage input synchroniser with rise/fall pulses
module dht_line_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/dht_reader.sv
// rtl/dht_reader.sv - single-wire DHT11/DHT22 reader: start pulse, 40-bit decode, checksum
module dht_reader
  import dht_pkg::*;
#(
  parameter int TICKS_PER_US  = 1,
  parameter int MODE          = MODE_DHT11,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 48,
  parameter int TIMEOUT_US    = 200,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk1M,
  input  logic        rst,
  input  logic        start,
  inout  wire         data_io,
  output logic        busy,
  output logic        valid,
  output logic        err_timeout,
  output logic        err_checksum,
  output logic [39:0] raw,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic [5:0]  bit_cnt
);

  localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICKS_PER_US - 1);
  localparam logic [15:0]      LOW_LAST    = 16'(START_LOW_US - 1);
  localparam logic [15:0]      THRESH_LIM  = 16'(BIT_THRESH_US);
  localparam logic [15:0]      TIMEOUT_LIM = 16'(TIMEOUT_US);

  dht_state_e       state_q, state_d;
  logic             drive_low_q, drive_low_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_checksum_q, err_checksum_d;
  dht_frame_t       raw_q, raw_d;
  dht_frame_t       shift_q, shift_d;
  logic [15:0]      humidity_q, humidity_d;
  logic [15:0]      temperature_q, temperature_d;
  logic [15:0]      us_q, us_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;

  logic       line_rise, line_fall, line_level_unused;
  logic       start_rise, start_level_unused, start_fall_unused;
  logic       tick, timed_out, bit_is_one;
  logic [7:0] b2, b1;

  dht_line_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_line_sync (
    .clk   (clk1M),
    .rst   (rst),
    .d     (data_io),
    .level (line_level_unused),
    .rise  (line_rise),
    .fall  (line_fall)
  );

  dht_line_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_start_sync (
    .clk   (clk1M),
    .rst   (rst),
    .d     (start),
    .level (start_level_unused),
    .rise  (start_rise),
    .fall  (start_fall_unused)
  );

  always_comb begin
    tick       = (pre_q == PRE_LAST);
    timed_out  = (us_q >= TIMEOUT_LIM);
    // Width in cycles is us_q*TICKS + pre_q; "greater than" needs the sub-us remainder.
    bit_is_one = (us_q > THRESH_LIM) || ((us_q == THRESH_LIM) && (pre_q != '0));
    b2         = shift_q[23:16];
    b1         = shift_q[15:8];

    state_d        = state_q;
    drive_low_d    = drive_low_q;
    busy_d         = busy_q;
    valid_d        = 1'b0;
    err_timeout_d  = 1'b0;
    err_checksum_d = 1'b0;
    raw_d          = raw_q;
    shift_d        = shift_q;
    humidity_d     = humidity_q;
    temperature_d  = temperature_q;
    bit_cnt_d      = bit_cnt_q;
    pre_d          = tick ? '0 : pre_q + PRE_W'(1);
    us_d           = (tick && (us_q != 16'hFFFF)) ? us_q + 16'd1 : us_q;

    case (state_q)
      ST_IDLE: begin
        drive_low_d = 1'b0;
        if (start_rise) begin
          state_d     = ST_START_LOW;
          drive_low_d = 1'b1;
          busy_d      = 1'b1;
          bit_cnt_d   = 6'd0;
        end
      end
      ST_START_LOW: begin
        if (tick && (us_q == LOW_LAST)) begin
          state_d     = ST_START_REL;
          drive_low_d = 1'b0;
        end
      end
      ST_START_REL: if (line_fall) state_d = ST_ACK_LOW;
      ST_ACK_LOW:   if (line_rise) state_d = ST_ACK_HIGH;
      ST_ACK_HIGH:  if (line_fall) state_d = ST_BIT_LOW;
      ST_BIT_LOW:   if (line_rise) state_d = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (line_fall) begin
          shift_d   = {shift_q[38:0], bit_is_one};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? ST_CHECK : ST_BIT_LOW;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (checksum_ok(shift_q)) begin
          valid_d    = 1'b1;
          raw_d      = shift_q;
          humidity_d = shift_q[39:24];
          if ((MODE == MODE_DHT22) && b2[7]) begin
            temperature_d = 16'd0 - {1'b0, b2[6:0], b1};
          end else begin
            temperature_d = {b2, b1};
          end
        end else begin
          err_checksum_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q inside {ST_START_REL, ST_ACK_LOW, ST_ACK_HIGH, ST_BIT_LOW, ST_BIT_HIGH})
        && timed_out) begin
      state_d       = ST_IDLE;
      busy_d        = 1'b0;
      err_timeout_d = 1'b1;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
    end

    // Every level change restarts the width/timeout measurement.
    if (state_d != state_q) begin
      pre_d = '0;
      us_d  = '0;
    end
  end

  always_ff @(posedge clk1M) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      drive_low_q    <= 1'b0;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_checksum_q <= 1'b0;
      raw_q          <= '0;
      shift_q        <= '0;
      humidity_q     <= '0;
      temperature_q  <= '0;
      us_q           <= '0;
      pre_q          <= '0;
      bit_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      drive_low_q    <= drive_low_d;
      busy_q         <= busy_d;
      valid_q        <= valid_d;
      err_timeout_q  <= err_timeout_d;
      err_checksum_q <= err_checksum_d;
      raw_q          <= raw_d;
      shift_q        <= shift_d;
      humidity_q     <= humidity_d;
      temperature_q  <= temperature_d;
      us_q           <= us_d;
      pre_q          <= pre_d;
      bit_cnt_q      <= bit_cnt_d;
    end
  end

  assign data_io      = drive_low_q ? 1'b0 : 1'bz;
  assign busy         = busy_q;
  assign valid        = valid_q;
  assign err_timeout  = err_timeout_q;
  assign err_checksum = err_checksum_q;
  assign raw          = raw_q;
  assign humidity     = humidity_q;
  assign temperature  = temperature_q;
  assign bit_cnt      = bit_cnt_q;

endmodule

// File: tb/tb_dht_reader.sv
// tb/tb_dht_reader.sv - self-checking bench for dht_reader (DHT11, DHT22 and 4-tick instances)
`timescale 1ns/1ps
module tb_dht_reader;
  import dht_pkg::*;

  localparam int KIND_VALID = 0;
  localparam int KIND_CKS   = 1;
  localparam int KIND_TMO   = 2;

  typedef struct {
    int          kind;
    logic [39:0] raw;
    logic [15:0] hum;
    logic [15:0] temp;
  } exp_t;

  typedef struct {
    int          inst;
    logic [39:0] frame;
    int          nbits;
    bit          restart;
    int          kind;
    logic [39:0] raw;
    logic [15:0] hum;
    logic [15:0] temp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, start_v, s_low;
  wire bus0, bus1, bus2;
  pullup (bus0);
  pullup (bus1);
  pullup (bus2);
  assign bus0 = s_low[0] ? 1'b0 : 1'bz;
  assign bus1 = s_low[1] ? 1'b0 : 1'bz;
  assign bus2 = s_low[2] ? 1'b0 : 1'bz;

  logic        busy0, valid0, to0, ck0, busy1, valid1, to1, ck1, busy2, valid2, to2, ck2;
  logic [39:0] raw0, raw1, raw2;
  logic [15:0] hum0, hum1, hum2, temp0, temp1, temp2;
  logic [5:0]  bc0, bc1, bc2;

  dht_reader #(.TICKS_PER_US(1), .MODE(MODE_DHT11), .START_LOW_US(100), .BIT_THRESH_US(48),
               .TIMEOUT_US(200), .SYNC_STAGES(2)) u0 (
    .clk1M(clk), .rst(rst_v[0]), .start(start_v[0]), .data_io(bus0), .busy(busy0),
    .valid(valid0), .err_timeout(to0), .err_checksum(ck0), .raw(raw0), .humidity(hum0),
    .temperature(temp0), .bit_cnt(bc0));

  dht_reader #(.TICKS_PER_US(1), .MODE(MODE_DHT22), .START_LOW_US(1000), .BIT_THRESH_US(48),
               .TIMEOUT_US(200), .SYNC_STAGES(2)) u1 (
    .clk1M(clk), .rst(rst_v[1]), .start(start_v[1]), .data_io(bus1), .busy(busy1),
    .valid(valid1), .err_timeout(to1), .err_checksum(ck1), .raw(raw1), .humidity(hum1),
    .temperature(temp1), .bit_cnt(bc1));

  dht_reader #(.TICKS_PER_US(4), .MODE(MODE_DHT11), .START_LOW_US(1000), .BIT_THRESH_US(48),
               .TIMEOUT_US(200), .SYNC_STAGES(2)) u2 (
    .clk1M(clk), .rst(rst_v[2]), .start(start_v[2]), .data_io(bus2), .busy(busy2),
    .valid(valid2), .err_timeout(to2), .err_checksum(ck2), .raw(raw2), .humidity(hum2),
    .temperature(temp2), .bit_cnt(bc2));

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=no_event required=event", name);
  endtask

  function automatic logic get_bus(input int idx);
    case (idx) 0: return bus0; 1: return bus1; default: return bus2; endcase
  endfunction
  function automatic logic get_busy(input int idx);
    case (idx) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic int q_size(input int idx);
    case (idx) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction

  task automatic push_exp(input int idx, input exp_t e);
    case (idx) 0: q0.push_back(e); 1: q1.push_back(e); default: q2.push_back(e); endcase
  endtask

  task automatic check_evt(input string who, input exp_t e, input logic v, input logic c,
                           input logic t, input logic b, input logic [39:0] r,
                           input logic [15:0] h, input logic [15:0] tp);
    logic [2:0] want;
    want = (e.kind == KIND_VALID) ? 3'b100 : (e.kind == KIND_CKS) ? 3'b010 : 3'b001;
    chk({who, "_pulse_kind"}, {v, c, t}, want);
    chk({who, "_busy_at_pulse"}, b, 1'b0);
    chk({who, "_raw"}, r, e.raw);
    chk({who, "_humidity"}, h, e.hum);
    chk({who, "_temperature"}, tp, e.temp);
  endtask

  // Scoreboard: every output pulse must match the oldest expectation of its instance.
  always @(negedge clk) begin
    if (valid0 | ck0 | to0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL u0_unexpected_pulse actual=%b%b%b required=none", valid0, ck0, to0);
      end else begin
        e0 = q0.pop_front();
        check_evt("u0", e0, valid0, ck0, to0, busy0, raw0, hum0, temp0);
      end
    end
    if (valid1 | ck1 | to1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL u1_unexpected_pulse actual=%b%b%b required=none", valid1, ck1, to1);
      end else begin
        e1 = q1.pop_front();
        check_evt("u1", e1, valid1, ck1, to1, busy1, raw1, hum1, temp1);
      end
    end
    if (valid2 | ck2 | to2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL u2_unexpected_pulse actual=%b%b%b required=none", valid2, ck2, to2);
      end else begin
        e2 = q2.pop_front();
        check_evt("u2", e2, valid2, ck2, to2, busy2, raw2, hum2, temp2);
      end
    end
  end

  task automatic wait_bus(input int idx, input logic lvl, input int max_cyc, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (get_bus(idx) !== lvl) begin
      @(negedge clk);
      n++;
      if (n >= max_cyc) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_drain(input int idx, input int max_cyc);
    int n;
    n = 0;
    while (q_size(idx) != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (q_size(idx) != 0) fail_note("event_wait");
  endtask

  // Sensor model: 80/80 us response, 50 us low + 26/70 us high per bit.
  task automatic sensor(input int idx, input logic [39:0] f, input int nbits);
    repeat (30) @(negedge clk);
    s_low[idx] = 1'b1;
    repeat (80) @(negedge clk);
    s_low[idx] = 1'b0;
    repeat (80) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      s_low[idx] = 1'b1;
      repeat (50) @(negedge clk);
      s_low[idx] = 1'b0;
      repeat (f[39-i] ? 70 : 26) @(negedge clk);
    end
    if (nbits == 40) begin
      s_low[idx] = 1'b1;
      repeat (50) @(negedge clk);
      s_low[idx] = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   ok;
    e.kind = v.kind;
    e.raw  = v.raw;
    e.hum  = v.hum;
    e.temp = v.temp;
    push_exp(v.inst, e);
    start_v[v.inst] = 1'b1;
    wait_bus(v.inst, 1'b0, 3000, ok);
    if (!ok) begin
      fail_note("host_low");
      start_v[v.inst] = 1'b0;
      return;
    end
    chk("busy_during_start", get_busy(v.inst), 1'b1);
    if (v.restart) begin
      repeat (5) @(negedge clk);
      start_v[v.inst] = 1'b0;
      repeat (3) @(negedge clk);
      start_v[v.inst] = 1'b1;
    end
    wait_bus(v.inst, 1'b1, 3000, ok);
    if (!ok) begin
      fail_note("host_release");
      start_v[v.inst] = 1'b0;
      return;
    end
    sensor(v.inst, v.frame, v.nbits);
    wait_drain(v.inst, 1000);
    repeat (20) @(negedge clk);
    chk("bus_released_after", get_bus(v.inst), 1'b1);
    chk("busy_after", get_busy(v.inst), 1'b0);
    start_v[v.inst] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    exp_t e;

    vecs[0] = '{0, 40'h35_00_18_00_4D, 40, 1'b1, KIND_VALID, 40'h35_00_18_00_4D, 16'h3500, 16'h1800};
    vecs[1] = '{0, 40'h35_00_18_00_4E, 40, 1'b0, KIND_CKS,   40'h35_00_18_00_4D, 16'h3500, 16'h1800};
    vecs[2] = '{0, 40'h28_00_1A_05_47, 40, 1'b0, KIND_VALID, 40'h28_00_1A_05_47, 16'h2800, 16'h1A05};
    vecs[3] = '{0, 40'h35_00_18_00_4D, 17, 1'b0, KIND_TMO,   40'h28_00_1A_05_47, 16'h2800, 16'h1A05};
    vecs[4] = '{1, 40'h02_8C_80_65_73, 40, 1'b0, KIND_VALID, 40'h02_8C_80_65_73, 16'd652,  16'hFF9B};
    vecs[5] = '{1, 40'h02_8C_00_65_F3, 40, 1'b0, KIND_VALID, 40'h02_8C_00_65_F3, 16'd652,  16'h0065};
    vecs[6] = '{1, 40'h02_8C_80_65_74, 40, 1'b0, KIND_CKS,   40'h02_8C_00_65_F3, 16'd652,  16'h0065};

    rst_v   = 3'b111;
    start_v = 3'b000;
    s_low   = 3'b000;
    repeat (5) @(negedge clk);
    rst_v = 3'b000;
    @(negedge clk);
    chk("rst_u0_busy", busy0, 1'b0);
    chk("rst_u0_pulses", {valid0, ck0, to0}, 3'b000);
    chk("rst_u0_raw", raw0, 40'h0);
    chk("rst_u0_hum_temp", {hum0, temp0}, 32'h0);
    chk("rst_u0_bitcnt", bc0, 6'd0);
    chk("rst_u0_bus", bus0, 1'b1);
    chk("rst_u1_outputs", {busy1, valid1, ck1, to1, raw1, hum1, temp1, bc1}, 0);
    chk("rst_u2_outputs", {busy2, valid2, ck2, to2, raw2, hum2, temp2, bc2}, 0);

    // Reset while the host is holding the line low: released on the reset edge.
    start_v[1] = 1'b1;
    wait_bus(1, 1'b0, 100, ok);
    if (!ok) fail_note("u1_host_low");
    repeat (10) @(negedge clk);
    rst_v[1]   = 1'b1;
    start_v[1] = 1'b0;
    @(negedge clk);
    chk("u1_rst_bus_released", bus1, 1'b1);
    chk("u1_rst_busy", busy1, 1'b0);
    repeat (3) @(negedge clk);
    rst_v[1] = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // 4 ticks/us: start latency and exact low-pulse length, then no sensor -> timeout.
    e = '{KIND_TMO, 40'h0, 16'h0, 16'h0};
    push_exp(2, e);
    @(posedge clk);
    #1;
    start_v[2] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (bus2 !== 1'b0 && n < 20);
    chk("u2_start_latency", n, 3);
    n = 0;
    while (bus2 === 1'b0 && n < 10000) begin
      n++;
      @(negedge clk);
    end
    chk("u2_low_cycles", n, 4000);
    wait_drain(2, 2000);
    @(negedge clk);
    chk("u2_bus_after_timeout", bus2, 1'b1);
    start_v[2] = 1'b0;

    // Reset while a bit's high phase is being measured.
    start_v[0] = 1'b1;
    wait_bus(0, 1'b0, 3000, ok);
    if (!ok) fail_note("u0_host_low");
    wait_bus(0, 1'b1, 3000, ok);
    if (!ok) fail_note("u0_host_release");
    sensor(0, 40'h35_00_18_00_4D, 10);
    repeat (20) @(negedge clk);
    chk("u0_bitcnt_mid", bc0, 6'd9);
    chk("u0_busy_mid", busy0, 1'b1);
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("u0_midrst_bus", bus0, 1'b1);
    chk("u0_midrst_flags", {busy0, valid0, ck0, to0}, 4'b0000);
    chk("u0_midrst_raw", raw0, 40'h0);
    chk("u0_midrst_hum_temp", {hum0, temp0}, 32'h0);
    chk("u0_midrst_bitcnt", bc0, 6'd0);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0;
    repeat (400) @(negedge clk);
    chk("u0_idle_after_rst", busy0, 1'b0);

    chk("scoreboard_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
